// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pulls bytes from an 8-bit synchronous FIFO (one-cycle
// registered read latency, write-over-read priority) and packs NBYTES of
// them into one word presented on a valid/ready interface.
// Optional feature macro: PACK_FLUSH_EN adds the flush input and the
// word_bytes output so a partial word can be emitted with its unfilled
// slots zeroed.
module fifo_word_packer #(
   parameter int NBYTES    = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [7:0]                   fifo_data,
   input  logic                         fifo_empty,
   input  logic                         fifo_wr_win,
   output logic                         fifo_rn,
   output logic [8*NBYTES-1:0]          word_out,
   output logic                         word_valid,
   input  logic                         word_ready
`ifdef PACK_FLUSH_EN
   ,
   input  logic                         flush,
   output logic [$clog2(NBYTES+1)-1:0]  word_bytes
`endif
);

   localparam int            CW       = $clog2(NBYTES + 1);
   localparam logic [CW:0]   NB_WIDE  = (CW + 1)'(NBYTES);
   localparam logic [CW-1:0] NB_CNT   = CW'(NBYTES);
   localparam logic [CW-1:0] TOP_SLOT = CW'(NBYTES - 1);

   typedef enum logic {ST_FILL, ST_HOLD} state_t;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic                r_pending;
   logic [8*NBYTES-1:0] r_word;
   logic                r_valid;

   logic [CW:0]         w_sum;
   logic                w_room;
   logic                w_acc;
   logic                w_stop;
   logic                w_flush_done;
   logic [CW-1:0]       w_cnt_next;
   logic [CW-1:0]       w_slot;

`ifdef PACK_FLUSH_EN
   logic [CW-1:0]       r_bytes;
   logic [NBYTES-1:0]   w_keep;

   // flush is live once any byte is held or in flight; it finishes only after
   // the in-flight byte has landed, so nothing already read is dropped
   always_comb begin
      w_stop       = flush && (r_state == ST_FILL) && ((r_cnt != '0) || r_pending);
      w_flush_done = flush && (r_state == ST_FILL) && (r_cnt != '0) && !r_pending;
   end

   // slots already holding bytes of the current word; the rest get zeroed
   always_comb begin
      w_keep = '0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (MSB_FIRST != 0)
            w_keep[i] = ((CW + 1)'(i) + {1'b0, r_cnt}) >= NB_WIDE;
         else
            w_keep[i] = CW'(i) < r_cnt;
      end
   end

   assign word_bytes = r_bytes;
`else
   // no flush hardware: only complete words leave the packer
   always_comb begin
      w_stop       = 1'b0;
      w_flush_done = 1'b0;
   end
`endif

   // read request: room for one more byte counting the one already in flight
   always_comb begin
      w_sum      = {1'b0, r_cnt} + {{CW{1'b0}}, r_pending};
      w_room     = w_sum < NB_WIDE;
      fifo_rn    = reset && (r_state == ST_FILL) && !fifo_empty && w_room && !w_stop;
      w_acc      = fifo_rn && !fifo_empty && !fifo_wr_win;
      w_cnt_next = r_cnt + CW'(1);
      w_slot     = (MSB_FIRST != 0) ? (TOP_SLOT - r_cnt) : r_cnt;
   end

   // packer state: capture in-flight byte, complete/flush word, handshake
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= ST_FILL;
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_word    <= '0;
         r_valid   <= 1'b0;
`ifdef PACK_FLUSH_EN
         r_bytes   <= '0;
`endif
      end else begin
         r_pending <= w_acc;
         case (r_state)
            ST_FILL: begin
               if (r_pending) begin
                  for (int unsigned i = 0; i < NBYTES; i++) begin
                     if (w_slot == CW'(i))
                        r_word[i*8 +: 8] <= fifo_data;
                  end
                  r_cnt <= w_cnt_next;
                  if (w_cnt_next == NB_CNT) begin
                     r_state <= ST_HOLD;
                     r_valid <= 1'b1;
`ifdef PACK_FLUSH_EN
                     r_bytes <= NB_CNT;
`endif
                  end
               end else if (w_flush_done) begin
`ifdef PACK_FLUSH_EN
                  for (int unsigned i = 0; i < NBYTES; i++) begin
                     if (!w_keep[i])
                        r_word[i*8 +: 8] <= '0;
                  end
                  r_bytes <= r_cnt;
`endif
                  r_state <= ST_HOLD;
                  r_valid <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (r_valid && word_ready) begin
                  r_state <= ST_FILL;
                  r_valid <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

   assign word_out   = r_word;
   assign word_valid = r_valid;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: drives two packers (LSB-first and MSB-first) from one
// byte-FIFO model; expected words are queued when bytes are pushed and
// compared when the packer hands a word off.
module tb_fifo_word_packer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  fifo_data = 8'h00;
   logic        fifo_empty = 1'b1;
   logic        fifo_wr_win = 1'b0;
   logic        word_ready = 1'b0;
   logic        rn0, rn1, v0, v1;
   logic [31:0] w0, w1;
`ifdef PACK_FLUSH_EN
   logic        flush = 1'b0;
   logic [2:0]  wb0, wb1;
`endif

   always #5 clock = ~clock;

   fifo_word_packer #(.NBYTES(4), .MSB_FIRST(0)) dut0 (
      .clock(clock), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_wr_win(fifo_wr_win), .fifo_rn(rn0), .word_out(w0), .word_valid(v0),
      .word_ready(word_ready)
`ifdef PACK_FLUSH_EN
      , .flush(flush), .word_bytes(wb0)
`endif
   );

   fifo_word_packer #(.NBYTES(4), .MSB_FIRST(1)) dut1 (
      .clock(clock), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_wr_win(fifo_wr_win), .fifo_rn(rn1), .word_out(w1), .word_valid(v1),
      .word_ready(word_ready)
`ifdef PACK_FLUSH_EN
      , .flush(flush), .word_bytes(wb1)
`endif
   );

   typedef struct {
      logic [31:0] lsb;
      logic [31:0] msb;
   } exp_t;

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] exp_lsb;
      logic [31:0] exp_msb;
      int          stall;
   } vec_t;

   logic [7:0] fifo_q[$];
   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   vec_t       vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      fifo_empty = 1'b0;
   endtask

   task automatic push_word(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      push_byte(b0); push_byte(b1); push_byte(b2); push_byte(b3);
   endtask

   task automatic push_exp(input logic [31:0] lsb, input logic [31:0] msb);
      exp_t e;
      e.lsb = lsb;
      e.msb = msb;
      exp_q.push_back(e);
   endtask

   // One clock: sample handshake and FIFO read at the falling edge, then
   // update the FIFO model's registered read data just after the rising edge.
   task automatic tick();
      logic acc;
      exp_t e;
      @(negedge clock);
      acc = rn0 && !fifo_empty && !fifo_wr_win;
      if (reset && v0 && word_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(w0), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("word_lsb_first", 64'(w0), 64'(e.lsb));
            check("word_msb_first", 64'(w1), 64'(e.msb));
`ifdef PACK_FLUSH_EN
            check("word_bytes_full", 64'(wb0), 64'd4);
`endif
         end
      end
      @(posedge clock);
      #1;
      if (acc) begin
         fifo_data  = fifo_q.pop_front();
         fifo_empty = (fifo_q.size() == 0);
      end
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (!v0 && n < budget) begin
         tick();
         n++;
      end
      check("wait_valid", 64'(v0), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] rn_pat;
      logic [7:0] v_pat;

      vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h4433_2211, 32'h1122_3344, 0};
      vecs[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBE_ADDE, 32'hDEAD_BEEF, 0};
      vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00_FF00, 32'h00FF_00FF, 3};
      vecs[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201, 32'h0102_0304, 5};
      vecs[4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC3_5AA5, 32'hA55A_C33C, 1};

      // reset held with a non-empty FIFO
      push_word(8'h11, 8'h22, 8'h33, 8'h44);
      push_exp(32'h4433_2211, 32'h1122_3344);
      word_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_ctl", 64'({rn0, rn1, v0, v1}), 64'd0);
         check("reset_word", {w0, w1}, 64'd0);
      end
      reset = 1'b1;
      wait_drain(20);

      // basic pack: exact read and valid timing
      rn_pat = 8'b0000_1111;
      v_pat  = 8'b0010_0000;
      push_word(8'h11, 8'h22, 8'h33, 8'h44);
      push_exp(32'h4433_2211, 32'h1122_3344);
      #1;
      for (int i = 0; i < 8; i++) begin
         check("basic_cycle", 64'({rn0, rn1, v0, v1}),
               64'({rn_pat[i], rn_pat[i], v_pat[i], v_pat[i]}));
         tick();
      end
      wait_drain(5);

      // table-driven words, some with the FIFO running dry mid-word
      for (int i = 0; i < 5; i++) begin
         push_byte(vecs[i].b0);
         push_byte(vecs[i].b1);
         push_exp(vecs[i].exp_lsb, vecs[i].exp_msb);
         for (int s = 0; s < vecs[i].stall; s++) begin
            tick();
            check("empty_midword_valid", 64'({v0, v1}), 64'd0);
         end
         push_byte(vecs[i].b2);
         push_byte(vecs[i].b3);
         wait_drain(20);
      end

`ifdef PACK_FLUSH_EN
      // flush of a 2-byte partial word over stale slots from the last word
      word_ready = 1'b0;
      push_byte(8'h11);
      push_byte(8'h22);
      for (int i = 0; i < 4; i++) tick();
      check("flush_pre_valid", 64'(v0), 64'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_valid", 64'({v0, v1}), 64'h3);
      check("flush_word", {w0, w1}, {32'h0000_2211, 32'h1122_0000});
      check("flush_bytes", 64'({wb0, wb1}), 64'({3'd2, 3'd2}));
      reset = 1'b0;
      tick();
      check("flush_reset_valid", 64'({v0, v1}), 64'd0);
      check("flush_reset_bytes", 64'(wb0), 64'd0);
      reset = 1'b1;
      flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("flush_idle_ignored", 64'({v0, rn0}), 64'd0);
      end
      flush = 1'b0;
      word_ready = 1'b1;
`endif

      // write collision on the second read
      push_word(8'h11, 8'h22, 8'h33, 8'h44);
      push_exp(32'h4433_2211, 32'h1122_3344);
      tick();
      fifo_wr_win = 1'b1;
      check("collide_rn", 64'(rn0), 64'd1);
      tick();
      fifo_wr_win = 1'b0;
      check("collide_reissue", 64'(rn0), 64'd1);
      wait_drain(20);
      check("collide_fifo_empty", 64'(fifo_q.size()), 64'd0);

      // backpressure across two words
      word_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      push_exp(32'h0403_0201, 32'h0102_0304);
      push_exp(32'h0807_0605, 32'h0506_0708);
      wait_valid(20);
      for (int i = 0; i < 10; i++) begin
         check("bp_hold_ctl", 64'({v0, v1, rn0}), 64'b110);
         check("bp_hold_word", {w0, w1}, {32'h0403_0201, 32'h0102_0304});
         tick();
      end
      word_ready = 1'b1;
      wait_drain(30);

      // reset with a byte in flight and a partial word
      push_word(8'h99, 8'h98, 8'h97, 8'h96);
      tick();
      tick();
      reset = 1'b0;
      fifo_q.delete();
      fifo_empty = 1'b1;
      tick();
      check("midreset_ctl", 64'({v0, rn0}), 64'd0);
      check("midreset_word", {w0, w1}, 64'd0);
      reset = 1'b1;
      push_word(8'h11, 8'h22, 8'h33, 8'h44);
      push_exp(32'h4433_2211, 32'h1122_3344);
      wait_drain(20);

      // reset during HOLD drops valid
      word_ready = 1'b0;
      push_word(8'h55, 8'h66, 8'h77, 8'h88);
      wait_valid(20);
      reset = 1'b0;
      tick();
      check("hold_reset_valid", 64'({v0, v1}), 64'd0);
      reset = 1'b1;
      tick();
      tick();
      check("final_idle", 64'({v0, rn0}), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the 8-bit synchronous FIFO.
- Pulls bytes via the FIFO read strobe, assembles NBYTES consecutive bytes into one word and presents the word on a valid/ready interface to the next stage.
- Models the FIFO's one-cycle registered read latency and its write-over-read priority, so no byte is lost or duplicated.

Parameters:
- NBYTES, 4, bytes per output word (2..8).
- MSB_FIRST, 0, 0: first byte read lands in bits [7:0]; 1: first byte lands in the top byte.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- fifo_data  input  8  FIFO read data; valid the cycle after an accepted read.
- fifo_empty  input  1  FIFO empty flag.
- fifo_wr_win  input  1  high when the FIFO write wins this cycle (FIFO wn & !full); a read issued that cycle is ignored by the FIFO.
- fifo_rn  output  1  FIFO read strobe.
- word_out  output  8*NBYTES  packed word.
- word_valid  output  1  word_out holds a complete word.
- word_ready  input  1  downstream accepts word_out.

Behaviour:
- Reset (reset low at a rising edge):
  - state=FILL, byte count cnt=0, pending=0, word_out=0, word_valid=0.
  - fifo_rn is combinationally forced 0 while reset is low.
- Accepted read: acc = fifo_rn & !fifo_empty & !fifo_wr_win.
- pending register: set to acc each cycle; means a byte arrives next cycle.
- FILL state:
  - fifo_rn = !fifo_empty & ((cnt + pending) < NBYTES).
  - This is combinational from registers and fifo_empty only; no path from word_ready.
  - Back-to-back reads are allowed, giving 1 byte/cycle throughput.
- Capture: when pending=1, fifo_data is written into byte slot cnt, and cnt increments.
  - Slot index is cnt when MSB_FIRST=0, else NBYTES-1-cnt.
- When a capture makes cnt reach NBYTES:
  - Go to HOLD and set word_valid=1 on the next cycle edge (same edge as the final capture).
  - cnt is held.
- HOLD state:
  - fifo_rn=0.
  - word_out and word_valid are stable until word_valid & word_ready.
- Handshake (word_valid & word_ready):
  - Return to FILL, word_valid=0, cnt=0.
  - word_out keeps its old value; the next word overwrites it slot by slot.
  - The first read of the next word may issue the cycle after the handshake.
- Latency: the last accepted read at cycle N gives word_valid at cycle N+2 (byte on fifo_data at N+1, captured at the end of N+1).
- fifo_wr_win collision: the read is not accepted and not counted; fifo_rn stays asserted next cycle if the condition still holds.
- FIFO empty mid-word: cnt holds; the partial word is retained indefinitely.
- Reset mid-operation:
  - The in-flight byte (pending=1) and the partial word are discarded.
  - Any word_valid is dropped.
- cnt width: clog2(NBYTES+1). Comparisons use unsigned arithmetic with no overflow (cnt+pending <= NBYTES).

Optional Feature:
- Macro PACK_FLUSH_EN.
- Defined:
  - Adds input flush (1) and output word_bytes (clog2(NBYTES+1)).
  - flush high in FILL with cnt>0:
    - Stops issuing reads.
    - Waits for any pending byte to be captured.
    - Then enters HOLD with the unfilled slots zeroed and word_bytes=cnt.
  - flush with cnt=0 and pending=0 is ignored.
  - A full word gives word_bytes=NBYTES.
  - word_bytes resets to 0.
- Undefined: no flush port and no word_bytes port; only complete words are emitted.

Test Plan:
- Reset: hold reset low 3 cycles with FIFO non-empty -> fifo_rn=0, word_valid=0, word_out=0x00000000 throughout.
- Basic pack: FIFO preloaded 0x11,0x22,0x33,0x44, word_ready=1 -> fifo_rn high 4 consecutive cycles; word_valid high exactly 1 cycle, 2 cycles after the last read, with word_out=0x44332211.
- Backpressure: 8 bytes 0x01..0x08, word_ready=0 for 10 cycles -> word_out=0x04030201 stable, fifo_rn=0 during HOLD; after word_ready=1, second word=0x08070605.
- Write collision: fifo_wr_win=1 on the cycle of the 2nd read -> that read is reissued next cycle; word_out=0x44332211, no duplicate or missing byte.
- MSB_FIRST=1, bytes 0x11,0x22,0x33,0x44 -> word_out=0x11223344; FIFO empties after 2 bytes -> word_valid stays 0 until the remaining bytes arrive.
- PACK_FLUSH_EN: 2 bytes 0x11,0x22 then flush=1 -> word_out=0x00002211, word_bytes=2; reset low during HOLD -> word_valid=0 next cycle.
